// File: rtl/home_cmd_scheduler_if.sv
// Command bus between the requesters, the scheduler and the actuator driver.
// master: the scheduler side; slave: the requesters plus the actuator driver.
interface home_cmd_scheduler_if;
    logic       req_app;
    logic [3:0] cmd_app;
    logic       req_ai;
    logic [3:0] cmd_ai;
    logic       req_robot;
    logic [3:0] cmd_robot;
    logic       access_granted;
    logic       bus_ready;
    logic       bus_valid;
    logic [3:0] bus_cmd;
    logic [1:0] bus_src;
    logic       ack_app;
    logic       ack_ai;
    logic       ack_robot;
    logic       app_deny;
    logic       timeout_err;
    logic       busy;

    modport master (
        input  req_app, cmd_app, req_ai, cmd_ai, req_robot, cmd_robot,
        input  access_granted, bus_ready,
        output bus_valid, bus_cmd, bus_src, ack_app, ack_ai, ack_robot,
        output app_deny, timeout_err, busy
    );

    modport slave (
        output req_app, cmd_app, req_ai, cmd_ai, req_robot, cmd_robot,
        output access_granted, bus_ready,
        input  bus_valid, bus_cmd, bus_src, ack_app, ack_ai, ack_robot,
        input  app_deny, timeout_err, busy
    );
endinterface

// File: rtl/home_cmd_scheduler.sv
// Home command scheduler: arbitrates app / AI / robot commands onto a single
// 4-bit actuator bus with valid/ready handshake and per-command timeout.
// Optional build macro SCHED_FIXED_PRIO_EN: fixed priority app > ai > robot
// instead of round-robin.
module home_cmd_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned TO_W           = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    home_cmd_scheduler_if.master  bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          state;
    logic [TO_W-1:0] to_cnt;
    logic            bus_valid_q;
    logic [3:0]      bus_cmd_q;
    logic [1:0]      bus_src_q;
    logic            ack_app_q;
    logic            ack_ai_q;
    logic            ack_robot_q;
    logic            app_deny_q;
    logic            timeout_err_q;
    logic            busy_q;

    logic [2:0]      elig;
    logic            win_any;
    logic [1:0]      win_src;
    logic [3:0]      win_cmd;

`ifndef SCHED_FIXED_PRIO_EN
    logic [1:0]      rr_ptr;
`endif

    // A zero command is never eligible; app additionally needs access.
    assign elig[0] = bus.req_app && bus.access_granted && (bus.cmd_app != 4'd0);
    assign elig[1] = bus.req_ai && (bus.cmd_ai != 4'd0);
    assign elig[2] = bus.req_robot && (bus.cmd_robot != 4'd0);
    assign win_any = |elig;

`ifdef SCHED_FIXED_PRIO_EN
    // Fixed priority winner: app > ai > robot.
    always_comb begin
        win_src = 2'd0;
        if (elig[0])      win_src = 2'd0;
        else if (elig[1]) win_src = 2'd1;
        else if (elig[2]) win_src = 2'd2;
    end
`else
    // Round-robin winner, search starting at rr_ptr.
    always_comb begin
        win_src = 2'd0;
        case (rr_ptr)
            2'd1: begin
                if (elig[1])      win_src = 2'd1;
                else if (elig[2]) win_src = 2'd2;
                else              win_src = 2'd0;
            end
            2'd2: begin
                if (elig[2])      win_src = 2'd2;
                else if (elig[0]) win_src = 2'd0;
                else              win_src = 2'd1;
            end
            default: begin
                if (elig[0])      win_src = 2'd0;
                else if (elig[1]) win_src = 2'd1;
                else              win_src = 2'd2;
            end
        endcase
    end
`endif

    // Command of the selected source.
    always_comb begin
        win_cmd = bus.cmd_app;
        case (win_src)
            2'd1:    win_cmd = bus.cmd_ai;
            2'd2:    win_cmd = bus.cmd_robot;
            default: win_cmd = bus.cmd_app;
        endcase
    end

    // Scheduler FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            to_cnt        <= '0;
            bus_valid_q   <= 1'b0;
            bus_cmd_q     <= 4'd0;
            bus_src_q     <= 2'd0;
            ack_app_q     <= 1'b0;
            ack_ai_q      <= 1'b0;
            ack_robot_q   <= 1'b0;
            app_deny_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
`ifndef SCHED_FIXED_PRIO_EN
            rr_ptr        <= 2'd0;
`endif
        end else begin
            ack_app_q     <= 1'b0;
            ack_ai_q      <= 1'b0;
            ack_robot_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            app_deny_q    <= bus.req_app && !bus.access_granted;
            case (state)
                IDLE: begin
                    if (win_any) begin
                        state       <= ISSUE;
                        bus_valid_q <= 1'b1;
                        bus_cmd_q   <= win_cmd;
                        bus_src_q   <= win_src;
                        busy_q      <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (bus.bus_ready || (to_cnt == TO_LAST)) begin
                        // Ready wins over a simultaneous timeout.
                        state         <= GAP;
                        bus_valid_q   <= 1'b0;
                        to_cnt        <= '0;
                        timeout_err_q <= !bus.bus_ready;
                        case (bus_src_q)
                            2'd1:    ack_ai_q    <= 1'b1;
                            2'd2:    ack_robot_q <= 1'b1;
                            default: ack_app_q   <= 1'b1;
                        endcase
`ifndef SCHED_FIXED_PRIO_EN
                        case (bus_src_q)
                            2'd0:    rr_ptr <= 2'd1;
                            2'd1:    rr_ptr <= 2'd2;
                            default: rr_ptr <= 2'd0;
                        endcase
`endif
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                GAP: begin
                    state  <= IDLE;
                    to_cnt <= '0;
                    busy_q <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    to_cnt      <= '0;
                    bus_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.bus_valid   = bus_valid_q;
    assign bus.bus_cmd     = bus_cmd_q;
    assign bus.bus_src     = bus_src_q;
    assign bus.ack_app     = ack_app_q;
    assign bus.ack_ai      = ack_ai_q;
    assign bus.ack_robot   = ack_robot_q;
    assign bus.app_deny    = app_deny_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.busy        = busy_q;

endmodule
